// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5-9 data bits, parity, 1 or 2 stops).
// Optional queue via `UART_TX_FIFO_EN; default build uses a single holding register.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int BAUD_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud_cnt,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  output logic              TX,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_q;
  logic [BAUD_W-1:0] cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              stop_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;

  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              bit_end;
  logic              frame_end;
  logic              new_par_en;
  logic              new_par_bit;

  assign bit_end   = (cnt_q == '0);
  assign frame_end = (state_q == S_STOP) && bit_end &&
                     (!stop2_q || stop_idx_q);

  assign push = wr_en && !full;
  assign pop  = !empty && ((state_q == S_IDLE) || frame_end);

  assign new_par_en  = (parity_mode == 2'b01) ||
                       (parity_mode == 2'b10);
  assign new_par_bit = (^head) ^ (parity_mode == 2'b10);

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       occ_q;
  logic [AW:0]       occ_d;

  assign full  = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (occ_q == '0);
  assign head  = mem_q[rptr_q];

  // Occupancy follows push/pop; push is already gated by full.
  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Queue storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      occ_q <= occ_d;
    end
  end
`else
  localparam logic HOLD_EN = (FIFO_DEPTH > 0);

  logic [DATA_W-1:0] hold_q;
  logic              valid_q;

  assign full  = valid_q & HOLD_EN;
  assign empty = !valid_q;
  assign head  = hold_q;

  // Single-entry holding register; push and pop never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= wr_data;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  // Sticky flag for any write offered while the queue was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q   <= S_START;
            cnt_q     <= baud_cnt;
            sh_q      <= head;
            par_en_q  <= new_par_en;
            par_bit_q <= new_par_bit;
            stop2_q   <= stop2;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= baud_cnt;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= baud_cnt;
            if (bit_q == BIT_W'(DATA_W-1)) begin
              if (par_en_q) begin
                state_q <= S_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= S_STOP;
                stop_idx_q <= 1'b0;
                tx_q       <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q    <= S_STOP;
            cnt_q      <= baud_cnt;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= baud_cnt;
            if (!frame_end) begin
              stop_idx_q <= 1'b1;
            end else if (pop) begin
              state_q   <= S_START;
              sh_q      <= head;
              par_en_q  <= new_par_en;
              par_bit_q <= new_par_bit;
              stop2_q   <= stop2;
              tx_q      <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign TX       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg.
// Covers both queue builds (`UART_TX_FIFO_EN defined or not).
module tb_uart_tx_cfg;

  typedef struct {
    logic [8:0] data;
    int         dw;
    logic [1:0] pm;
    logic       s2;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [12:0] baud_cnt;
  logic [1:0]  parity_mode;
  logic        stop2;

  logic        wr_en8;
  logic [7:0]  wr_data8;
  logic        full8, ovf8, tx8, busy8, done8;

  logic        wr_en5;
  logic [4:0]  wr_data5;
  logic        full5, ovf5, tx5, busy5, done5;

  bit          mon_sel;
  logic        tx_mon, busy_mon, done_mon;

  frame_t      sb[$];
  int          total;
  int          bad;
  int          first_wait;

  uart_tx_cfg #(.DATA_W(8), .BAUD_W(13), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .baud_cnt(baud_cnt),
    .parity_mode(parity_mode), .stop2(stop2),
    .wr_en(wr_en8), .wr_data(wr_data8),
    .full(full8), .overflow(ovf8), .TX(tx8),
    .tx_busy(busy8), .tx_done(done8)
  );

  uart_tx_cfg #(.DATA_W(5), .BAUD_W(13), .FIFO_DEPTH(4)) u_dut5 (
    .clk(clk), .rst(rst), .baud_cnt(baud_cnt),
    .parity_mode(parity_mode), .stop2(stop2),
    .wr_en(wr_en5), .wr_data(wr_data5),
    .full(full5), .overflow(ovf5), .TX(tx5),
    .tx_busy(busy5), .tx_done(done5)
  );

  assign tx_mon   = mon_sel ? tx5   : tx8;
  assign busy_mon = mon_sel ? busy5 : busy8;
  assign done_mon = mon_sel ? done5 : done8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [8:0] d, input bit accept);
    frame_t e;
    if (accept) begin
      e.data = mon_sel ? {4'b0, d[4:0]} : {1'b0, d[7:0]};
      e.dw   = mon_sel ? 5 : 8;
      e.pm   = parity_mode;
      e.s2   = stop2;
      sb.push_back(e);
    end
    if (mon_sel) begin
      wr_en5   = 1'b1;
      wr_data5 = d[4:0];
    end else begin
      wr_en8   = 1'b1;
      wr_data8 = d[7:0];
    end
    @(negedge clk);
    wr_en5 = 1'b0;
    wr_en8 = 1'b0;
  endtask

  task automatic check_frames(input int n, input int first_limit,
                              input string nm);
    for (int f = 0; f < n; f++) begin
      frame_t     e;
      logic [15:0] eb;
      int         nb;
      int         w;
      int         lim;
      bit         found;
      lim   = (f == 0) ? first_limit : 1;
      found = 1'b0;
      w     = 0;
      while (!found && w < lim) begin
        @(negedge clk);
        w++;
        if (tx_mon === 1'b0) found = 1'b1;
      end
      if (f == 0) first_wait = w;
      total++;
      if (!found) begin
        bad++;
        $display("FAIL %s start%0d: tx=%b after %0d cycles, required 0 within %0d",
                 nm, f, tx_mon, w, lim);
        return;
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s sb%0d: got a frame, scoreboard empty", nm, f);
        return;
      end
      e  = sb.pop_front();
      eb = '1;
      eb[0] = 1'b0;
      nb = 1;
      for (int i = 0; i < e.dw; i++) begin
        eb[nb] = e.data[i];
        nb++;
      end
      if (e.pm == 2'b01 || e.pm == 2'b10) begin
        eb[nb] = (^e.data) ^ (e.pm == 2'b10);
        nb++;
      end
      eb[nb] = 1'b1;
      nb++;
      if (e.s2) begin
        eb[nb] = 1'b1;
        nb++;
      end
      for (int k = 0; k < nb; k++) begin
        for (int j = 0; j <= int'(baud_cnt); j++) begin
          if (k != 0 || j != 0) @(negedge clk);
          total++;
          if (tx_mon !== eb[k]) begin
            bad++;
            $display("FAIL %s f%0d bit%0d cyc%0d: tx=%b required %b",
                     nm, f, k, j, tx_mon, eb[k]);
          end
          if (j == 0) begin
            total++;
            if (done_mon !== 1'b0 || busy_mon !== 1'b1) begin
              bad++;
              $display("FAIL %s f%0d bit%0d status: done=%b busy=%b required 0 1",
                       nm, f, k, done_mon, busy_mon);
            end
          end
        end
      end
    end
    @(negedge clk);
    total++;
    if (done_mon !== 1'b1 || busy_mon !== 1'b0 || tx_mon !== 1'b1) begin
      bad++;
      $display("FAIL %s end: done=%b busy=%b tx=%b required 1 0 1",
               nm, done_mon, busy_mon, tx_mon);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: %0d frames unsent, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_not_full(input string nm);
    int w;
    w = 0;
    while (full8 === 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (full8 !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s full_wait: full=%b after %0d cycles, required 0", nm, full8, w);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (tx8 !== 1'b1) begin bad++; $display("FAIL rst_tx: tx=%b required 1", tx8); end
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_busy: busy=%b required 0", busy8); end
    total++;
    if (done8 !== 1'b1) begin bad++; $display("FAIL rst_done: done=%b required 1", done8); end
    total++;
    if (full8 !== 1'b0) begin bad++; $display("FAIL rst_full: full=%b required 0", full8); end
    total++;
    if (ovf8 !== 1'b0) begin bad++; $display("FAIL rst_ovf: ovf=%b required 0", ovf8); end
    total++;
    if (tx5 !== 1'b1 || done5 !== 1'b1) begin
      bad++;
      $display("FAIL rst_dut5: tx=%b done=%b required 1 1", tx5, done5);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    mon_sel = 1'b0;
    baud_cnt = 13'd3;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    fork
      check_frames(1, 2, "8n1");
      send(9'h0A5, 1'b1);
    join
    total++;
    if (first_wait != 2) begin
      bad++;
      $display("FAIL 8n1_latency: start seen at sample %0d, required 2", first_wait);
    end
  endtask

  task automatic test_parity_stop2();
    mon_sel = 1'b0;
    baud_cnt = 13'd2;
    parity_mode = 2'b10;
    stop2 = 1'b1;
    fork
      check_frames(1, 2, "odd2s");
      send(9'h003, 1'b1);
      begin
        repeat (8) @(negedge clk);
        parity_mode = 2'b01;
        stop2 = 1'b0;
      end
    join
  endtask

  task automatic test_back_to_back();
    logic [8:0] words [3];
    words[0] = 9'h05A;
    words[1] = 9'h0FF;
    words[2] = 9'h000;
    mon_sel = 1'b0;
    baud_cnt = 13'd1;
    parity_mode = 2'b01;
    stop2 = 1'b0;
    fork
      check_frames(3, 2, "b2b");
      begin
        for (int i = 0; i < 3; i++) begin
          wait_not_full("b2b");
          send(words[i], 1'b1);
        end
      end
    join
  endtask

  task automatic test_narrow();
    mon_sel = 1'b1;
    baud_cnt = 13'd0;
    parity_mode = 2'b01;
    stop2 = 1'b0;
    fork
      check_frames(1, 2, "narrow");
      send(9'h01F, 1'b1);
    join
    mon_sel = 1'b0;
  endtask

  task automatic test_overflow();
    mon_sel = 1'b0;
    baud_cnt = 13'd100;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    total++;
    if (ovf8 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pre: ovf=%b required 0", ovf8);
    end
`ifdef UART_TX_FIFO_EN
    fork
      check_frames(5, 2, "ovf");
      begin
        for (int i = 0; i < 6; i++) begin
          send(9'(8'h10 + i), i < 5);
          if (i == 3) begin
            total++;
            if (full8 !== 1'b0) begin
              bad++;
              $display("FAIL ovf_full4: full=%b required 0", full8);
            end
          end
          if (i == 4) begin
            total++;
            if (full8 !== 1'b1) begin
              bad++;
              $display("FAIL ovf_full5: full=%b required 1", full8);
            end
          end
        end
        total++;
        if (ovf8 !== 1'b1) begin
          bad++;
          $display("FAIL ovf_flag: ovf=%b required 1", ovf8);
        end
      end
    join
`else
    fork
      check_frames(2, 2, "ovf");
      begin
        for (int i = 0; i < 3; i++) begin
          send(9'(8'h10 + i), i != 1);
          if (i == 0) begin
            total++;
            if (full8 !== 1'b1) begin
              bad++;
              $display("FAIL ovf_full1: full=%b required 1", full8);
            end
          end
        end
        total++;
        if (ovf8 !== 1'b1) begin
          bad++;
          $display("FAIL ovf_flag: ovf=%b required 1", ovf8);
        end
      end
    join
`endif
  endtask

  task automatic test_reset_mid();
    int lows;
    mon_sel = 1'b0;
    baud_cnt = 13'd3;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    send(9'h000, 1'b1);
    wait_not_full("rmid");
    send(9'h000, 1'b1);
    repeat (12) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (tx8 !== 1'b1) begin bad++; $display("FAIL rmid_tx: tx=%b required 1", tx8); end
    total++;
    if (done8 !== 1'b1) begin bad++; $display("FAIL rmid_done: done=%b required 1", done8); end
    total++;
    if (full8 !== 1'b0) begin bad++; $display("FAIL rmid_full: full=%b required 0", full8); end
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL rmid_busy: busy=%b required 0", busy8); end
    total++;
    if (ovf8 !== 1'b0) begin bad++; $display("FAIL rmid_ovf: ovf=%b required 0", ovf8); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || done8 !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL rmid_resume: %0d active cycles after reset, required 0", lows);
    end
  endtask

  initial begin
    rst = 1'b1;
    baud_cnt = 13'd3;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    wr_en8 = 1'b0;
    wr_data8 = '0;
    wr_en5 = 1'b0;
    wr_data5 = '0;
    mon_sel = 1'b0;
    total = 0;
    bad = 0;
    first_wait = 0;
    test_reset();
    test_8n1();
    test_parity_stop2();
    test_back_to_back();
    test_narrow();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter that replaces the fixed 8N1 transmitter in the serial output path. It sends frames of 5–9 data bits, LSB first, with optional even or odd parity and one or two stop bits. The bit period is programmable at run time. Bytes are queued in a small write FIFO, so back-to-back frames leave the line with zero idle gap.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; legal range 5–9.
- BAUD_W, 13, width of the bit-period count.
- FIFO_DEPTH, 4, transmit queue entries; power of two, at least 2; used only with UART_TX_FIFO_EN.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- baud_cnt  in  BAUD_W  bit period minus one, in clk cycles.
- parity_mode  in  2  parity select: 00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  stop bits: 1 selects two, 0 selects one.
- wr_en  in  1  write strobe, one cycle per data word.
- wr_data  in  DATA_W  data word to queue.
- full  out  1  queue cannot accept a write.
- overflow  out  1  sticky flag: a write was dropped.
- TX  out  1  serial output; idles high.
- tx_busy  out  1  a frame is on the line.
- tx_done  out  1  last frame finished and queue empty; held high until the next frame starts.

## Operation
- Reset values, applied asynchronously:
  - TX=1, tx_busy=0, tx_done=1, full=0, overflow=0.
  - Queue emptied, state IDLE.
- Queue behaviour:
  - A write with wr_en=1 and full=0 is pushed at the clock edge.
  - A write with full=1 is dropped and sets overflow. This holds even if a pop happens in the same cycle.
  - full reflects the registered occupancy.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the queue is not empty: pop the head word and latch parity_mode and stop2 into frame-local registers.
  - Then go to START, with tx_busy=1 and tx_done=0.
- START: drive 0 for one bit period.
- DATA:
  - Drive the latched word LSB first for DATA_W bit periods.
  - A bit counter runs 0..DATA_W-1.
- PARITY (entered only if the latched mode is 01 or 10):
  - Even mode: drive the XOR of the data bits.
  - Odd mode: drive the inverse of that XOR.
- STOP: drive 1 for one bit period, or two if the latched stop2 is set.
- End of the final stop bit:
  - If the queue is not empty, pop and enter START at that same edge (zero-gap back-to-back frames).
  - Otherwise go to IDLE, with tx_busy=0 and tx_done=1.
- Configuration changes:
  - Changes to parity_mode and stop2 during a frame have no effect until the next frame.
  - baud_cnt is sampled at every bit-period reload, so a change applies from the next bit.
- Bit period:
  - The down-counter loads baud_cnt at frame start and at each bit boundary.
  - The bit advances when the counter reaches 0, so each bit lasts baud_cnt+1 cycles.
  - baud_cnt=0 gives 1-cycle bits.
- TX is driven from a flop with no combinational path from the inputs.
- A reset mid-frame aborts the frame: TX goes high immediately and queued data is lost.

## Timing
- Write latency: wr_en at edge N into an empty queue while IDLE makes the start bit begin at edge N+1.
- Frame length in cycles: (baud_cnt+1) × (1 + DATA_W + P + S).
  - P=1 when parity is on, otherwise 0.
  - S = 1 + stop2.
- tx_done rises at the edge that ends the final stop bit.
- tx_done falls at the edge where the next start bit begins.
- A write in the same cycle as a pop from a full queue is still dropped; full drops one cycle later.

## Configuration
- UART_TX_FIFO_EN defined:
  - The queue has FIFO_DEPTH entries.
  - full asserts when occupancy equals FIFO_DEPTH.
- UART_TX_FIFO_EN undefined:
  - The queue is a single holding register; FIFO_DEPTH is ignored.
  - full asserts while the register is occupied.
  - Back-to-back, overflow and tx_done rules are otherwise identical.

## Test plan
- Default 8N1: DATA_W=8, baud_cnt=3, parity 00, stop2=0; write 8'hA5.
  - TX low 1 cycle after the write, then 1,0,1,0,0,1,0,1, then a stop bit; 4 cycles per bit.
  - tx_done high after 40 cycles.
- Parity and two stops: odd parity, stop2=1, word 8'h03.
  - Parity bit = 1.
  - Frame length 12 × (baud_cnt+1).
  - Changing parity_mode mid-frame does not alter the frame.
- Back-to-back: write 3 words on consecutive cycles (FIFO on).
  - Three contiguous frames, no idle cycle between them.
  - tx_done low throughout, high only after frame 3.
- Overflow: FIFO_DEPTH=4, baud_cnt=100, write 6 words back-to-back.
  - full after 5 writes (4 queued plus 1 popped).
  - 6th write dropped, overflow=1, 5 frames sent.
- Narrow word and fast baud: DATA_W=5, baud_cnt=0, even parity, word 5'h1F.
  - 1-cycle bits, parity bit 1, frame length 8 cycles.
- Reset mid-frame: assert rst during DATA.
  - TX=1, tx_done=1, full=0 immediately.
  - No frame resumes after rst deasserts.
